// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle for uart_rx_fifo: receiver capture side, FWFT consumer side and status.
// The FIFO takes the slave modport; whatever drives the receiver and consumer side takes master.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [8:0]          rxData;
  logic                rxDataReceived;
  logic                rxParityError;
  logic                rxBreak;
  logic                rxOverflow;
  logic                rxAck;
  logic [8:0]          outData;
  logic                outParityError;
  logic                outBreak;
  logic                outValid;
  logic                outReady;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                empty;
  logic                overrunSticky;
  logic                clearStatus;
  logic                timeout;

  modport slave (
    input  rxData, rxDataReceived, rxParityError, rxBreak, rxOverflow,
    input  outReady, clearStatus,
    output rxAck, outData, outParityError, outBreak, outValid,
    output count, full, empty, overrunSticky, timeout
  );

  modport master (
    output rxData, rxDataReceived, rxParityError, rxBreak, rxOverflow,
    output outReady, clearStatus,
    input  rxAck, outData, outParityError, outBreak, outValid,
    input  count, full, empty, overrunSticky, timeout
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: acks each character into a 2^DEPTH_LOG2 FWFT buffer.
// Optional idle-character timeout is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
`ifdef UART_RX_FIFO_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [PW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_write;
  logic            w_pop;
  logic            r_rxAck;
  logic            r_overrun;
  logic [10:0]     r_mem [DEPTH];
  logic [10:0]     w_head;

  assign w_count = r_wrPtr - r_rdPtr;
  assign w_full  = (w_count == PW'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_pop   = !w_empty && bus.outReady;

  // ACK state is a one-cycle holdoff while the receiver drops dataReceived
  always_comb begin
    w_nextState = r_state;
    w_write     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rxDataReceived && !w_full) begin
          w_write     = 1'b1;
          w_nextState = S_ACK;
        end
      end
      S_ACK: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rxAck <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_rxAck <= w_write;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wrPtr[DEPTH_LOG2-1:0]] <= {bus.rxBreak, bus.rxParityError, bus.rxData};
    end
  end

  // A new overflow in the same cycle as a clear must not be lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (bus.rxOverflow) begin
      r_overrun <= 1'b1;
    end else if (bus.clearStatus) begin
      r_overrun <= 1'b0;
    end
  end

  assign w_head             = r_mem[r_rdPtr[DEPTH_LOG2-1:0]];
  assign bus.outData        = w_head[8:0];
  assign bus.outParityError = w_head[9];
  assign bus.outBreak       = w_head[10];
  assign bus.outValid       = !w_empty;
  assign bus.rxAck          = r_rxAck;
  assign bus.count          = w_count;
  assign bus.full           = w_full;
  assign bus.empty          = w_empty;
  assign bus.overrunSticky  = r_overrun;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_toCount;
  logic          r_timeout;
  logic          w_toIdle;

  assign w_toIdle = !w_empty && !w_write && !w_pop;

  // Counter saturates so a cleared timeout stays clear until new FIFO activity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_toCount <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_toIdle) begin
        r_toCount <= '0;
      end else if (r_toCount != TW'(TIMEOUT_CYCLES)) begin
        r_toCount <= r_toCount + TW'(1);
      end
      if (w_pop || bus.clearStatus || w_empty) begin
        r_timeout <= 1'b0;
      end else if (w_toIdle && (r_toCount == TW'(TIMEOUT_CYCLES - 1))) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH_LOG2=2) with a behavioural receiver that holds each
// character until acked and raises overflow when a new one arrives while one is still pending.
module tb_uart_rx_fifo;

  localparam int DL = 2;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic EXP_TIMEOUT = 1'b1;
`else
  localparam logic EXP_TIMEOUT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   ackPulses   = 0;
  int   ackWide     = 0;
  int   ackBase     = 0;
  logic prevAck     = 1'b0;

  logic [8:0] charData [5];
  logic       charPe   [5];
  logic       charBrk  [5];

  uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  uart_rx_fifo #(
    .DEPTH_LOG2(DL)
`ifdef UART_RX_FIFO_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Moves from one falling edge to the next; the receiver model reacts to rxAck at the rising edge
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      logic a;
      a = bus.rxAck;
      if (a) begin
        ackPulses++;
        if (prevAck) ackWide++;
      end
      prevAck = a;
      @(posedge clk);
      #1;
      if (a) bus.rxDataReceived = 1'b0;
      bus.rxOverflow = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] d, input logic pe, input logic brk);
    if (bus.rxDataReceived) begin
      bus.rxOverflow = 1'b1;
    end else begin
      bus.rxData         = d;
      bus.rxParityError  = pe;
      bus.rxBreak        = brk;
      bus.rxDataReceived = 1'b1;
    end
  endtask

  task automatic popExpect(input string tag, input logic [8:0] d, input logic pe, input logic brk);
    checkOutput({tag, ".valid"}, 32'(bus.outValid), 32'd1);
    checkOutput({tag, ".data"}, 32'(bus.outData), 32'(d));
    checkOutput({tag, ".pe"}, 32'(bus.outParityError), 32'(pe));
    checkOutput({tag, ".brk"}, 32'(bus.outBreak), 32'(brk));
    bus.outReady = 1'b1;
    advance(1);
    bus.outReady = 1'b0;
  endtask

  initial begin
    logic [8:0] d;
    charData = '{9'h011, 9'h122, 9'h033, 9'h1C4, 9'h055};
    charPe   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    charBrk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst                = 1'b0;
    bus.rxData         = '0;
    bus.rxDataReceived = 1'b0;
    bus.rxParityError  = 1'b0;
    bus.rxBreak        = 1'b0;
    bus.rxOverflow     = 1'b0;
    bus.outReady       = 1'b0;
    bus.clearStatus    = 1'b0;
    advance(3);

    checkOutput("rst.ack", 32'(bus.rxAck), 32'd0);
    checkOutput("rst.valid", 32'(bus.outValid), 32'd0);
    checkOutput("rst.count", 32'(bus.count), 32'd0);
    checkOutput("rst.empty", 32'(bus.empty), 32'd1);
    checkOutput("rst.full", 32'(bus.full), 32'd0);
    checkOutput("rst.overrun", 32'(bus.overrunSticky), 32'd0);
    checkOutput("rst.timeout", 32'(bus.timeout), 32'd0);
    rst = 1'b1;
    advance(1);

    // Two characters with the consumer stalled
    ackPulses = 0;
    applyStimulus(9'h060, 1'b0, 1'b0);
    advance(1);
    checkOutput("lat.ack", 32'(bus.rxAck), 32'd1);
    checkOutput("lat.count", 32'(bus.count), 32'd1);
    checkOutput("lat.valid", 32'(bus.outValid), 32'd1);
    advance(1);
    checkOutput("lat.ackDrop", 32'(bus.rxAck), 32'd0);
    applyStimulus(9'h0A5, 1'b0, 1'b0);
    advance(3);
    checkOutput("s1.count", 32'(bus.count), 32'd2);
    checkOutput("s1.ackPulses", 32'(ackPulses), 32'd2);
    checkOutput("s1.ackWide", 32'(ackWide), 32'd0);
    popExpect("s1.pop0", 9'h060, 1'b0, 1'b0);
    checkOutput("s1.countAfterPop", 32'(bus.count), 32'd1);
    popExpect("s1.pop1", 9'h0A5, 1'b0, 1'b0);
    checkOutput("s1.empty", 32'(bus.empty), 32'd1);

    // Fill to full, then a held 5th character and an overflowing 6th
    for (int i = 0; i < 4; i++) begin
      applyStimulus(charData[i], charPe[i], charBrk[i]);
      advance(2);
    end
    checkOutput("s2.count", 32'(bus.count), 32'd4);
    checkOutput("s2.full", 32'(bus.full), 32'd1);
    checkOutput("s2.empty", 32'(bus.empty), 32'd0);
    ackBase = ackPulses;
    applyStimulus(charData[4], charPe[4], charBrk[4]);
    advance(4);
    checkOutput("s2.noAck5", 32'(ackPulses), 32'(ackBase));
    checkOutput("s2.countHeld", 32'(bus.count), 32'd4);
    checkOutput("s2.overrunPre", 32'(bus.overrunSticky), 32'd0);
    applyStimulus(9'h166, 1'b0, 1'b0);
    advance(1);
    checkOutput("s2.overrunSet", 32'(bus.overrunSticky), 32'd1);
    advance(3);
    checkOutput("s2.overrunHold", 32'(bus.overrunSticky), 32'd1);
    bus.rxOverflow  = 1'b1;
    bus.clearStatus = 1'b1;
    advance(1);
    checkOutput("s2.setWins", 32'(bus.overrunSticky), 32'd1);
    advance(1);
    bus.clearStatus = 1'b0;
    checkOutput("s2.cleared", 32'(bus.overrunSticky), 32'd0);

    // Pop from full while the receiver still holds a character
    checkOutput("s3.head", 32'(bus.outData), 32'(charData[0]));
    bus.outReady = 1'b1;
    advance(1);
    bus.outReady = 1'b0;
    checkOutput("s3.popCount", 32'(bus.count), 32'd3);
    checkOutput("s3.popNoAck", 32'(bus.rxAck), 32'd0);
    advance(1);
    checkOutput("s3.capCount", 32'(bus.count), 32'd4);
    checkOutput("s3.capAck", 32'(bus.rxAck), 32'd1);
    for (int i = 1; i < 5; i++) begin
      popExpect($sformatf("s3.pop%0d", i), charData[i], charPe[i], charBrk[i]);
    end
    checkOutput("s3.empty", 32'(bus.empty), 32'd1);
    bus.outReady = 1'b1;
    advance(2);
    bus.outReady = 1'b0;
    checkOutput("s3.readyEmptyCount", 32'(bus.count), 32'd0);
    checkOutput("s3.readyEmptyValid", 32'(bus.outValid), 32'd0);

    // Same-cycle write and pop
    applyStimulus(9'h0AA, 1'b0, 1'b0);
    advance(2);
    applyStimulus(9'h0BB, 1'b0, 1'b0);
    bus.outReady = 1'b1;
    advance(1);
    bus.outReady = 1'b0;
    checkOutput("simul.count", 32'(bus.count), 32'd1);
    checkOutput("simul.head", 32'(bus.outData), 32'h0BB);
    advance(1);
    popExpect("simul.pop", 9'h0BB, 1'b0, 1'b0);

    // Pointer wrap
    for (int i = 0; i < 20; i++) begin
      d = 9'((i * 37 + 5) & 32'h1FF);
      applyStimulus(d, 1'b0, 1'b0);
      advance(2);
      checkOutput($sformatf("wrap%0d.count", i), 32'(bus.count), 32'd1);
      popExpect($sformatf("wrap%0d", i), d, 1'b0, 1'b0);
    end
    checkOutput("wrap.empty", 32'(bus.empty), 32'd1);

    // Idle-character timeout (stays 0 in the default build)
    applyStimulus(9'h077, 1'b0, 1'b0);
    advance(1);
    advance(49);
    checkOutput("to.before", 32'(bus.timeout), 32'd0);
    advance(1);
    checkOutput("to.at", 32'(bus.timeout), 32'(EXP_TIMEOUT));
    bus.clearStatus = 1'b1;
    advance(1);
    bus.clearStatus = 1'b0;
    checkOutput("to.clear", 32'(bus.timeout), 32'd0);
    advance(5);
    checkOutput("to.staysClear", 32'(bus.timeout), 32'd0);
    popExpect("to.pop", 9'h077, 1'b0, 1'b0);
    checkOutput("to.afterPop", 32'(bus.timeout), 32'd0);

    // Asynchronous reset with an ack in flight
    applyStimulus(9'h0CC, 1'b0, 1'b0);
    advance(1);
    checkOutput("mid.ackBefore", 32'(bus.rxAck), 32'd1);
    rst = 1'b0;
    bus.rxDataReceived = 1'b0;
    #1;
    checkOutput("mid.ack", 32'(bus.rxAck), 32'd0);
    checkOutput("mid.count", 32'(bus.count), 32'd0);
    checkOutput("mid.valid", 32'(bus.outValid), 32'd0);
    advance(2);
    rst = 1'b1;
    advance(2);
    checkOutput("mid.emptyAfter", 32'(bus.empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
